// File: rtl/ring_pkg.sv
// Shared types and helpers for the ring-counter sequence checker.
// Decode helper supports ring widths up to RING_MAX_N bits.
package ring_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } ring_state_t;

    // Ring advances by rotate-right: next = {cur[0], cur[N-1:1]}, so index steps i -> i-1.
    localparam bit RING_ROTATE_RIGHT = 1'b1;

    localparam int RING_MAX_N     = 64;
    localparam int RING_IDX_MAX_W = 6;

    typedef struct packed {
        logic                      legal;
        logic [RING_IDX_MAX_W-1:0] idx;
    } ring_dec_t;

    function automatic ring_dec_t onehot_to_idx(input logic [RING_MAX_N-1:0] code);
        ring_dec_t   res;
        int unsigned cnt;
        cnt       = 0;
        res.idx   = '0;
        res.legal = 1'b0;
        for (int i = 0; i < RING_MAX_N; i++) begin
            if (code[i]) begin
                cnt     = cnt + 1;
                res.idx = i[RING_IDX_MAX_W-1:0];
            end
        end
        res.legal = (cnt == 1);
        return res;
    endfunction

endpackage

// File: rtl/ring_onehot_decode.sv
// Combinational one-hot decoder: legal when exactly one bit is set, idx is that bit's position.
// Latency 0; no flow control.
module ring_onehot_decode
    import ring_pkg::*;
#(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     code,
    output logic             legal,
    output logic [IDX_W-1:0] idx
);

    logic [RING_MAX_N-1:0] w_code_ext;
    ring_dec_t             w_dec;
    logic                  w_unused_idx_par;

    always_comb begin
        w_code_ext         = '0;
        w_code_ext[N-1:0]  = code;
        w_dec              = onehot_to_idx(w_code_ext);
    end

    assign legal            = w_dec.legal;
    assign idx              = w_dec.idx[IDX_W-1:0];
    // Upper index bits are always zero for N below the package maximum.
    assign w_unused_idx_par = ^w_dec.idx;

endmodule

// File: rtl/ring_sequence_checker.sv
// Ring-code monitor: decodes each valid sample, checks one-hot legality and successor order, counts laps/errors.
// Latency 1 cycle, all outputs registered; ring_valid=0 holds state and clears error pulses.
module ring_sequence_checker
    import ring_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int LAP_W = 8,
    parameter  int ERR_W = 8,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     ring_in,
    input  logic             ring_valid,
    output logic [IDX_W-1:0] index,
    output logic             index_valid,
    output logic             onehot_err,
    output logic             seq_err,
    output logic [LAP_W-1:0] lap_count,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] WRAP_IDX = RING_ROTATE_RIGHT ? LAST_IDX : IDX_W'(0);

    ring_state_t      r_state, w_state_nxt;
    logic [IDX_W-1:0] r_index, w_index_nxt;
    logic             r_onehot_err, w_onehot_nxt;
    logic             r_seq_err, w_seq_nxt;
    logic [LAP_W-1:0] r_lap, w_lap_nxt;
    logic [ERR_W-1:0] r_err, w_err_nxt;
    logic             w_err_inc;
    logic             w_legal;
    logic [IDX_W-1:0] w_dec_idx;
    logic [IDX_W-1:0] w_expected;

    ring_onehot_decode #(.N(N)) u_decode (
        .code  (ring_in),
        .legal (w_legal),
        .idx   (w_dec_idx)
    );

    always_comb begin
        if (RING_ROTATE_RIGHT) begin
            w_expected = (r_index == '0) ? LAST_IDX : r_index - IDX_W'(1);
        end else begin
            w_expected = (r_index == LAST_IDX) ? IDX_W'(0) : r_index + IDX_W'(1);
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_index_nxt  = r_index;
        w_onehot_nxt = 1'b0;
        w_seq_nxt    = 1'b0;
        w_lap_nxt    = r_lap;
        w_err_inc    = 1'b0;
        if (ring_valid) begin
            if (!w_legal) begin
                // Index is kept so consumers still see the last good slot after losing lock.
                w_onehot_nxt = 1'b1;
                w_err_inc    = 1'b1;
                w_state_nxt  = UNLOCKED;
            end else begin
                w_index_nxt = w_dec_idx;
                w_state_nxt = LOCKED;
                if (r_state == UNLOCKED) begin
                    w_lap_nxt = '0;
                end else if (w_dec_idx == w_expected) begin
                    if (w_dec_idx == WRAP_IDX) begin
                        w_lap_nxt = r_lap + LAP_W'(1);
                    end
                end else begin
                    w_seq_nxt = 1'b1;
                    w_err_inc = 1'b1;
                end
            end
        end
        w_err_nxt = (w_err_inc && (r_err != '1)) ? r_err + ERR_W'(1) : r_err;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= UNLOCKED;
            r_index      <= '0;
            r_onehot_err <= 1'b0;
            r_seq_err    <= 1'b0;
            r_lap        <= '0;
            r_err        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_onehot_err <= w_onehot_nxt;
            r_seq_err    <= w_seq_nxt;
            r_lap        <= w_lap_nxt;
            r_err        <= w_err_nxt;
        end
    end

    assign index       = r_index;
    assign index_valid = (r_state == LOCKED);
    assign onehot_err  = r_onehot_err;
    assign seq_err     = r_seq_err;
    assign lap_count   = r_lap;
    assign err_count   = r_err;

endmodule

// File: tb/tb_ring_sequence_checker.sv
// Bench for ring_sequence_checker: directed scenarios plus random stimulus against a rule-level model.
module tb_ring_sequence_checker;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic [3:0] ring_in;
    logic       ring_valid;

    logic [1:0] index,  index_s;
    logic       index_valid, index_valid_s;
    logic       onehot_err, onehot_err_s;
    logic       seq_err, seq_err_s;
    logic [7:0] lap_count, lap_count_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_locked, m_idx, m_lap, m_err8, m_err2;
    int m_oh, m_seq;

    ring_sequence_checker #(.N(N), .LAP_W(8), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .ring_in(ring_in), .ring_valid(ring_valid),
        .index(index), .index_valid(index_valid), .onehot_err(onehot_err),
        .seq_err(seq_err), .lap_count(lap_count), .err_count(err_count)
    );

    ring_sequence_checker #(.N(N), .LAP_W(8), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .ring_in(ring_in), .ring_valid(ring_valid),
        .index(index_s), .index_valid(index_valid_s), .onehot_err(onehot_err_s),
        .seq_err(seq_err_s), .lap_count(lap_count_s), .err_count(err_count_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 0; m_idx = 0; m_lap = 0; m_err8 = 0; m_err2 = 0;
        m_oh = 0; m_seq = 0;
    endtask

    task automatic model_bump_err();
        if (m_err8 < 255) m_err8++;
        if (m_err2 < 3)   m_err2++;
    endtask

    task automatic model_step(input logic [3:0] code, input logic v);
        int ones, pos;
        m_oh = 0;
        m_seq = 0;
        if (v) begin
            ones = $countones(code);
            pos = 0;
            for (int i = 0; i < N; i++) if (code[i]) pos = i;
            if (ones != 1) begin
                m_oh = 1;
                model_bump_err();
                m_locked = 0;
            end else if (m_locked == 0) begin
                m_locked = 1;
                m_idx = pos;
                m_lap = 0;
            end else if (pos == (m_idx + N - 1) % N) begin
                m_idx = pos;
                if (pos == N - 1) m_lap = (m_lap + 1) % 256;
            end else begin
                m_seq = 1;
                model_bump_err();
                m_idx = pos;
            end
        end
    endtask

    task automatic check_all(input string where);
        check({where, ":index"},       32'(index),         32'(m_idx));
        check({where, ":index_valid"}, 32'(index_valid),   32'(m_locked));
        check({where, ":onehot_err"},  32'(onehot_err),    32'(m_oh));
        check({where, ":seq_err"},     32'(seq_err),       32'(m_seq));
        check({where, ":lap_count"},   32'(lap_count),     32'(m_lap));
        check({where, ":err_count"},   32'(err_count),     32'(m_err8));
        check({where, ":err_sat"},     32'(err_count_s),   32'(m_err2));
        check({where, ":index_sat"},   32'(index_s),       32'(m_idx));
    endtask

    task automatic step(input string where, input logic [3:0] code, input logic v);
        ring_in    = code;
        ring_valid = v;
        @(posedge clk);
        model_step(code, v);
        #1;
        check_all(where);
    endtask

    function automatic logic [3:0] succ_code();
        logic [3:0] one;
        one = 4'b0001;
        return one << ((m_idx + N - 1) % N);
    endfunction

    initial begin
        logic [3:0] c;
        int sel;
        clk = 1'b0;
        rst = 1'b1;
        ring_in = 4'b0000;
        ring_valid = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean lock and rotation
        step("seq0", 4'b0001, 1'b1);
        step("seq1", 4'b1000, 1'b1);
        step("seq2", 4'b0100, 1'b1);
        step("seq3", 4'b0010, 1'b1);
        step("seq4", 4'b0001, 1'b1);
        step("seq5", 4'b1000, 1'b1);
        step("seq6", 4'b0100, 1'b1);

        // Illegal code while locked, then relock
        step("bad_oh", 4'b0110, 1'b1);
        step("relock", 4'b0010, 1'b1);
        step("post_relock", 4'b0001, 1'b1);
        step("to_1000", 4'b1000, 1'b1);

        // Wrong successor
        step("seq_skip", 4'b0010, 1'b1);
        step("after_skip", 4'b0001, 1'b1);

        // Valid low with garbage on the bus
        for (int k = 0; k < 5; k++) step("hold", 4'b1111, 1'b0);
        step("resume", 4'b1000, 1'b1);
        step("stall", 4'b1000, 1'b1);

        // Repeated all-zero samples drive the narrow counter into saturation
        for (int k = 0; k < 5; k++) step("zeros", 4'b0000, 1'b1);
        step("zero_clear", 4'b0001, 1'b0);

        // Random mix
        for (int k = 0; k < 300; k++) begin
            sel = $urandom_range(0, 9);
            if (sel < 6) begin
                c = (m_locked != 0) ? succ_code() : (4'b0001 << $urandom_range(0, 3));
                step("rnd", c, 1'b1);
            end else if (sel == 6) begin
                c = 4'b0001 << $urandom_range(0, 3);
                step("rnd", c, 1'b1);
            end else if (sel == 7) begin
                c = 4'($urandom);
                step("rnd", c, 1'b1);
            end else if (sel == 8) begin
                c = 4'b0001 << m_idx;
                step("rnd", c, 1'b1);
            end else begin
                c = 4'($urandom);
                step("rnd", c, 1'b0);
            end
        end

        // Build lap_count up to 7 then reset between edges
        step("unlock", 4'b0000, 1'b1);
        step("lock0", 4'b0001, 1'b1);
        for (int k = 0; k < 40 && m_lap < 7; k++) step("laps", succ_code(), 1'b1);
        check("lap7", 32'(lap_count), 32'd7);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_lock", 4'b0100, 1'b1);
        step("post_rst_next", 4'b0010, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
